// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit five-stage core: widths, reset PC,
// opcode constants and the fetch controller state encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W   = 8;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  // IF/ID field widths, matching the instruction word layout {aux, rs, rt, opcode}
  localparam int unsigned OP_W     = 3;
  localparam int unsigned AUX_W    = 3;
  localparam int unsigned INSTR_W  = OP_W + 1 + 1 + AUX_W;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_LD   = 3'b100;
  localparam logic [OP_W-1:0] OP_ST   = 3'b101;
  localparam logic [OP_W-1:0] OP_BEQ  = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch controller, instruction memory, decode,
// hazard unit and EXE redirect path.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);

  logic              start;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  logic [ADDR_W-1:0] imem_addr;
  logic [2:0]        imem_opcode;
  logic              imem_rt;
  logic              imem_rs;
  logic [2:0]        imem_aux;

  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [2:0]        id_opcode;
  logic              id_rt;
  logic              id_rs;
  logic [2:0]        id_aux;

  logic              busy;
  logic              halted;

  modport master (
    output start, stall, redirect, redirect_pc,
    output imem_opcode, imem_rt, imem_rs, imem_aux,
    input  imem_addr,
    input  id_valid, id_pc, id_opcode, id_rt, id_rs, id_aux,
    input  busy, halted
  );

  modport slave (
    input  start, stall, redirect, redirect_pc,
    input  imem_opcode, imem_rt, imem_rs, imem_aux,
    output imem_addr,
    output id_valid, id_pc, id_opcode, id_rt, id_rs, id_aux,
    output busy, halted
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears only the valid bit, enable loads
// the whole entry, otherwise the entry holds.
module if_id_reg #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [2:0]        d_opcode,
  input  logic              d_rt,
  input  logic              d_rs,
  input  logic [2:0]        d_aux,
  output logic              q_valid,
  output logic [ADDR_W-1:0] q_pc,
  output logic [2:0]        q_opcode,
  output logic              q_rt,
  output logic              q_rs,
  output logic [2:0]        q_aux
);

  logic              valid_q,  valid_d;
  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [2:0]        opcode_q, opcode_d;
  logic              rt_q,     rt_d;
  logic              rs_q,     rs_d;
  logic [2:0]        aux_q,    aux_d;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    rt_d     = rt_q;
    rs_d     = rs_q;
    aux_d    = aux_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (en) begin
      valid_d  = 1'b1;
      pc_d     = d_pc;
      opcode_d = d_opcode;
      rt_d     = d_rt;
      rs_d     = d_rs;
      aux_d    = d_aux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      opcode_q <= '0;
      rt_q     <= 1'b0;
      rs_q     <= 1'b0;
      aux_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      rt_q     <= rt_d;
      rs_q     <= rs_d;
      aux_q    <= aux_d;
    end
  end

  assign q_valid  = valid_q;
  assign q_pc     = pc_q;
  assign q_opcode = opcode_q;
  assign q_rt     = rt_q;
  assign q_rs     = rs_q;
  assign q_aux    = aux_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives instruction-memory
// address, and sequences start, stall, redirect and halt into IF/ID.
module fetch_sequencer #(
  parameter int unsigned                  ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]            RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [cpu_pkg::OP_W-1:0]     HALT_OP  = cpu_pkg::OP_HALT
) (
  input  logic              sysclk,
  input  logic              reset,
  fetch_sequencer_if.slave  bus
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ifid_en;
  logic              ifid_flush;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ifid_flush = 1'b1;
        if (bus.redirect) pc_d = bus.redirect_pc;
        if (bus.start)    state_d = ST_RUN;
      end
      ST_RUN: begin
        // redirect outranks stall: the flushed slot makes the frozen entry moot
        if (bus.redirect) begin
          pc_d       = bus.redirect_pc;
          ifid_flush = 1'b1;
        end else if (!bus.stall) begin
          ifid_en = 1'b1;
          if (bus.imem_opcode == HALT_OP) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      ST_HALT: begin
        if (bus.redirect) begin
          pc_d       = bus.redirect_pc;
          ifid_flush = 1'b1;
          state_d    = ST_RUN;
        end else if (!bus.stall) begin
          ifid_flush = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ifid_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id (
    .clk      (sysclk),
    .rst      (reset),
    .en       (ifid_en),
    .flush    (ifid_flush),
    .d_pc     (pc_q),
    .d_opcode (bus.imem_opcode),
    .d_rt     (bus.imem_rt),
    .d_rs     (bus.imem_rs),
    .d_aux    (bus.imem_aux),
    .q_valid  (bus.id_valid),
    .q_pc     (bus.id_pc),
    .q_opcode (bus.id_opcode),
    .q_rt     (bus.id_rt),
    .q_rs     (bus.id_rs),
    .q_aux    (bus.id_aux)
  );

  assign bus.imem_addr = pc_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.halted    = (state_q == ST_HALT);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the 8-bit five-stage core (IF ID EXE MEM WB). Owns the program counter and drives the instruction-memory address, registers the decoded fields into the IF/ID pipeline register, and sequences start, stall, branch redirect and halt. Sits between the instruction memory (combinational read, 256 × 8-bit) and the decode stage; redirect and stall come from the EXE stage and the hazard unit.

## Interface
- ADDR_W, 8, PC / instruction-address width
- RESET_PC, 8'h00, PC value loaded on reset
- HALT_OP, 3'b111, opcode that stops fetch
- sysclk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle pulse; begins fetch from current PC when IDLE
- stall  in  1  hazard unit; freezes PC and IF/ID
- redirect  in  1  taken branch/jump from EXE
- redirect_pc  in  8  branch target
- imem_addr  out  8  address to instruction memory (= PC register)
- imem_opcode  in  3  instruction bits [2:0]
- imem_rt  in  1  instruction bit [3]
- imem_rs  in  1  instruction bit [4]
- imem_aux  in  3  instruction bits [7:5]
- id_valid  out  1  IF/ID holds a live instruction
- id_pc  out  8  address of the IF/ID instruction
- id_opcode, id_rt, id_rs, id_aux  out  3/1/1/3  registered decoded fields
- busy  out  1  state is RUN
- halted  out  1  state is HALT

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE.
- Reset values: pc=RESET_PC, id_valid=0, id_pc=0, id_opcode=0, id_rt=0, id_rs=0, id_aux=0, busy=0, halted=0.
- IDLE: no fetch, id_valid=0. start → RUN. redirect in IDLE loads pc, stays IDLE.
- RUN, per cycle, priority order:
  - redirect: pc←redirect_pc; id_valid←0 (flush bubble); stall ignored.
  - stall: pc, id_* all hold (id_valid included).
  - else: IF/ID ← {imem fields, id_pc←pc, id_valid←1}; pc←pc+1 mod 256 (8'hFF → 8'h00).
  - Fetched opcode == HALT_OP (unstalled, no redirect): instruction captured with id_valid=1, pc holds at halt address, → HALT.
- HALT: no fetch; cycle after entry id_valid←0 unless stall holds it. redirect (older branch resolving) → RUN, pc←redirect_pc, id_valid←0. start ignored. Only reset or redirect exits.
- start while RUN or HALT: ignored.
- Reset mid-operation: immediate asynchronous return to reset values regardless of state.
- No arithmetic beyond pc+1, modulo 2^ADDR_W.

## Timing
- imem_addr is registered PC; memory read combinational; IF/ID captures the same cycle → 1-cycle fetch latency.
- start at edge n → RUN after n; first id_valid=1 after edge n+1 with id_pc=RESET_PC.
- Sustained RUN, no stalls: one instruction per cycle, id_pc increments by 1.
- redirect sampled at edge k → one bubble (id_valid=0) after k; target instruction in IF/ID after k+1.
- stall is combinational-free: sampled at edge only, outputs change only on edges.
- busy/halted are decoded from the state register (no combinational input paths to outputs).

## Structure
- Shared package cpu_pkg: ADDR_W, RESET_PC, opcode constants (incl. OP_HALT = 3'b111), fetch state enum {IDLE, RUN, HALT}, IF/ID field widths.
- One natural sub-module: if_id_reg (enable, flush, async reset; holds valid, pc, opcode, rt, rs, aux). PC and FSM stay in fetch_sequencer.

## Test plan
- Reset then start with memory 0x00..0x04 = non-halt words → id_pc 0,1,2,3 on consecutive cycles, id_valid=1, fields match bit slices of each word.
- stall held 3 cycles at pc=2 → imem_addr stays 2, id_pc stays 1, id_valid stays 1; release → id_pc=2 next cycle.
- redirect to 8'h40 asserted together with stall at pc=5 → next cycle id_valid=0, imem_addr=8'h40; following cycle id_pc=8'h40.
- Word at 0x03 with opcode 3'b111 → id_pc=3 id_opcode=7, halted=1, imem_addr stays 3, id_valid=0 next cycle; start ignored; redirect to 8'h10 → busy=1, fetch resumes at 8'h10.
- redirect to 8'hFE, run 4 cycles → id_pc 0xFE, 0xFF, 0x00, 0x01 (wrap-around).
- Assert reset asynchronously mid-RUN at pc=0x20 → outputs immediately at reset values, state IDLE, imem_addr=RESET_PC.
